// File: rtl/ad7985_emulator.sv
// ---------------------------------------------------------------------------
// ad7985_emulator
//
// Behavioural stand-in for an AD7985-style SAR ADC, clocked entirely by the
// local system clock. The ADC controller drives CNV and SCK asynchronously;
// both are synchronised and edge-detected here, so every pin edge takes
// effect three clk cycles after it happens.
//
// A CNV rising edge captures a sample (internal ramp or ext_sample), holds
// busy high for a fixed conversion time, then presents the word on SDO MSB
// first. Each SCK falling edge advances SDO by one bit; after the sixteenth
// falling edge the block goes idle with SDO low. A CNV rising edge during
// the readout aborts it, pulses overrun and starts a fresh conversion.
//
// Parameters
//   CONV_CYCLES        conversion length in clk cycles with TURBIO = 0
//   CONV_CYCLES_TURBO  conversion length in clk cycles with TURBIO = 1
//
// Ports
//   clk         system clock, the only clock of the block
//   reset_n     asynchronous active-low reset
//   CNV         conversion start pin (asynchronous to clk)
//   SCK         serial read clock pin (asynchronous to clk)
//   TURBIO      conversion-time select, 1 = turbo
//   mode        sample source: 0 = internal ramp, 1 = ext_sample
//   ext_sample  externally supplied 16-bit sample
//   SDO         serial data out, MSB first
//   busy        high while a conversion is in progress
//   overrun     one-cycle pulse when a readout is cut short by a new CNV
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module ad7985_emulator #(
  parameter int CONV_CYCLES       = 40,
  parameter int CONV_CYCLES_TURBO = 28
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        CNV,
  input  logic        SCK,
  input  logic        TURBIO,
  input  logic        mode,
  input  logic [15:0] ext_sample,
  output logic        SDO,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    READY,
    READOUT
  } state_t;

  // The counter is loaded with N-1 and the block leaves CONVERT on the cycle
  // after it reaches zero, which keeps busy high for exactly N cycles.
  localparam logic [15:0] CONV_LOAD       = 16'(CONV_CYCLES - 1);
  localparam logic [15:0] CONV_LOAD_TURBO = 16'(CONV_CYCLES_TURBO - 1);

  // -------------------------------------------------------------------------
  // Pin synchronisers and edge detection
  // -------------------------------------------------------------------------
  // Bits [1:0] are the two-flop synchroniser, bit [2] is the delayed copy
  // used to find edges.
  logic [2:0] cnv_sync;
  logic [2:0] sck_sync;

  // CNV must be seen low by the synchroniser after reset before a rising edge
  // counts; otherwise a CNV held high through reset release would look like
  // a fresh 0->1 transition as the zeroed flops fill up.
  logic [1:0] sync_fill;
  logic       cnv_armed;

  // NOTE: every flop in this block, including the synchronisers, is cleared
  // by the asynchronous reset so the block is in a known state the instant
  // reset_n falls, with no dependency on clk running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnv_sync  <= '0;
      sck_sync  <= '0;
      sync_fill <= '0;
      cnv_armed <= 1'b0;
    end else begin
      // NOTE: sequential state is always updated with non-blocking
      // assignments so every flop samples pre-edge values, exactly like the
      // hardware shift chain it describes.
      cnv_sync <= {cnv_sync[1:0], CNV};
      sck_sync <= {sck_sync[1:0], SCK};
      if (sync_fill != 2'd2) begin
        sync_fill <= sync_fill + 2'd1;
      end
      // Once both synchroniser stages hold real pin samples, the first low
      // observation arms rising-edge detection.
      if (sync_fill == 2'd2 && !cnv_sync[1]) begin
        cnv_armed <= 1'b1;
      end
    end
  end

  logic cnv_rise;
  logic sck_fall;

  // CNV falling edges and SCK rising edges are deliberately not decoded.
  assign cnv_rise = cnv_armed & cnv_sync[1] & ~cnv_sync[2];
  assign sck_fall = ~sck_sync[1] & sck_sync[2];

  // -------------------------------------------------------------------------
  // Conversion / readout state machine
  // -------------------------------------------------------------------------
  state_t      state;
  logic [15:0] sreg;
  logic [15:0] ramp_cnt;
  logic [15:0] conv_cnt;
  logic [3:0]  bit_cnt;

  logic [15:0] sample_value;
  logic        in_readout;
  logic        start_conv;

  assign sample_value = mode ? ext_sample : ramp_cnt;
  assign in_readout   = (state == READY) || (state == READOUT);

  // A CNV edge during CONVERT is ignored; in every other state it starts a
  // conversion. In READY/READOUT it also wins over a simultaneous SCK fall.
  assign start_conv   = cnv_rise && (state != CONVERT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      sreg     <= '0;
      ramp_cnt <= '0;
      conv_cnt <= '0;
      bit_cnt  <= '0;
      SDO      <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;

      if (start_conv) begin
        // Abandoning an unfinished readout is what overrun reports.
        overrun  <= in_readout;
        sreg     <= sample_value;
        ramp_cnt <= ramp_cnt + 16'd1;
        conv_cnt <= TURBIO ? CONV_LOAD_TURBO : CONV_LOAD;
        bit_cnt  <= '0;
        busy     <= 1'b1;
        SDO      <= 1'b0;
        state    <= CONVERT;
      end else begin
        unique case (state)
          IDLE: begin
            SDO  <= 1'b0;
            busy <= 1'b0;
          end

          CONVERT: begin
            if (conv_cnt == 16'd0) begin
              busy  <= 1'b0;
              SDO   <= sreg[15];
              state <= READY;
            end else begin
              conv_cnt <= conv_cnt - 16'd1;
            end
          end

          READY, READOUT: begin
            if (sck_fall) begin
              if (bit_cnt == 4'd15) begin
                // Sixteenth falling edge: the word is fully delivered.
                bit_cnt <= '0;
                sreg    <= '0;
                SDO     <= 1'b0;
                state   <= IDLE;
              end else begin
                // SDO takes the bit that the shift is about to expose.
                sreg    <= {sreg[14:0], 1'b0};
                SDO     <= sreg[14];
                bit_cnt <= bit_cnt + 4'd1;
                state   <= READOUT;
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ad7985_emulator.sv
// ---------------------------------------------------------------------------
// tb_ad7985_emulator
//
// Directed bench for ad7985_emulator with default parameters (40 / 28
// cycle conversions). Pins are driven the way an ADC controller would:
// CNV pulses of a few clk cycles, SCK idling low with slow high/low phases
// so every synchronised edge has settled before SDO is sampled. Expected
// words and timings are hand-computed constants.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ad7985_emulator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        CNV;
  logic        SCK;
  logic        TURBIO;
  logic        mode;
  logic [15:0] ext_sample;
  logic        SDO;
  logic        busy;
  logic        overrun;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ad7985_emulator #(
    .CONV_CYCLES       (40),
    .CONV_CYCLES_TURBO (28)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .CNV        (CNV),
    .SCK        (SCK),
    .TURBIO     (TURBIO),
    .mode       (mode),
    .ext_sample (ext_sample),
    .SDO        (SDO),
    .busy       (busy),
    .overrun    (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Raise CNV, then measure edge-to-busy latency, busy width, overrun pulses
  // and any non-zero SDO while busy. Optional disturbances: a second CNV
  // pulse and SCK toggling inside the conversion, or an SCK fall launched on
  // the very same clk edge as CNV.
  task automatic start_conv(input bit repulse, input bit sck_tog, input bit with_fall,
                            output int lat, output int width, output int ovr,
                            output int sdo_bad);
    lat = 0; width = 0; ovr = 0; sdo_bad = 0;
    @(negedge clk);
    CNV = 1'b1;
    if (with_fall) SCK = 1'b0;
    while (lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (overrun) ovr++;
      if (busy) break;
    end
    if (busy) begin
      width = 1;
      if (SDO) sdo_bad++;
      for (int c = 1; c < 200; c++) begin
        @(posedge clk); #1;
        if (overrun) ovr++;
        if (c == 3) CNV = 1'b0;
        if (repulse && c == 10) CNV = 1'b1;
        if (repulse && c == 15) CNV = 1'b0;
        if (sck_tog && c >= 5 && c < 31) SCK = ((c % 4) >= 2);
        if (sck_tog && c == 31) SCK = 1'b0;
        if (!busy) break;
        width++;
        if (SDO) sdo_bad++;
      end
    end
    CNV = 1'b0;
  endtask

  task automatic run_conv(input string tag, input bit repulse, input bit sck_tog,
                          input bit with_fall, input int exp_width, input int exp_ovr);
    int lat, width, ovr, sdo_bad;
    start_conv(repulse, sck_tog, with_fall, lat, width, ovr, sdo_bad);
    check({tag, "_latency"}, lat, 3);
    check({tag, "_busy_width"}, width, exp_width);
    check({tag, "_overrun"}, ovr, exp_ovr);
    check({tag, "_sdo_busy"}, sdo_bad, 0);
  endtask

  // Sample SDO before each SCK falling edge; n bits land right-justified.
  task automatic read_bits(input int n, output logic [15:0] w);
    w = '0;
    for (int i = 0; i < n; i++) begin
      w = {w[14:0], SDO};
      SCK = 1'b1;
      repeat (4) @(negedge clk);
      SCK = 1'b0;
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic read_word(input string tag, input logic [15:0] exp);
    logic [15:0] w;
    read_bits(16, w);
    check({tag, "_word"}, w, exp);
    check({tag, "_sdo_after"}, SDO, 1'b0);
  endtask

  initial begin
    logic [15:0] part;
    int busy_seen;

    reset_n = 1'b0; CNV = 1'b0; SCK = 1'b0;
    TURBIO = 1'b0; mode = 1'b0; ext_sample = '0;

    repeat (3) @(negedge clk);
    check("rst_sdo", SDO, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", busy, 1'b0);

    // Ramp source, normal conversion time: 0x0000 then 0x0001.
    run_conv("ramp0", 0, 0, 0, 40, 0);
    read_word("ramp0", 16'h0000);
    run_conv("ramp1", 0, 0, 0, 40, 0);
    read_word("ramp1", 16'h0001);

    // External sample, turbo conversion time.
    mode = 1'b1; ext_sample = 16'hA5C3; TURBIO = 1'b1;
    run_conv("ext", 0, 0, 0, 28, 0);
    read_word("ext", 16'hA5C3);

    // Abort after 7 bits of 0xF0F0; the restart samples ramp = 4.
    TURBIO = 1'b0; ext_sample = 16'hF0F0;
    run_conv("pre_ovr", 0, 0, 0, 40, 0);
    read_bits(7, part);
    check("partial7", part, 16'h0078);
    mode = 1'b0;
    run_conv("ovr", 0, 0, 0, 40, 1);
    read_word("after_ovr", 16'h0004);

    // CNV rise and SCK fall on the same clk edge: CNV wins.
    run_conv("pre_tie", 0, 0, 0, 40, 0);
    read_bits(5, part);
    check("partial5", part, 16'h0000);
    SCK = 1'b1;
    repeat (4) @(negedge clk);
    run_conv("tie", 0, 0, 1, 40, 1);
    read_word("after_tie", 16'h0006);

    // SCK activity in IDLE, CNV re-pulse and SCK activity in CONVERT.
    for (int i = 0; i < 8; i++) begin
      SCK = ~SCK;
      repeat (2) @(negedge clk);
    end
    SCK = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_sck_busy", busy, 1'b0);
    check("idle_sck_sdo", SDO, 1'b0);
    run_conv("noise", 1, 1, 0, 40, 0);
    read_word("noise", 16'h0007);

    // Ramp wrap.
    @(negedge clk);
    force dut.ramp_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.ramp_cnt;
    TURBIO = 1'b1;
    run_conv("wrap_a", 0, 0, 0, 28, 0);
    read_word("wrap_a", 16'hFFFF);
    run_conv("wrap_b", 0, 0, 0, 28, 0);
    read_word("wrap_b", 16'h0000);

    // Reset at bit 9 of an all-ones readout, CNV held high across release.
    mode = 1'b1; ext_sample = 16'hFFFF;
    run_conv("pre_rst", 0, 0, 0, 28, 0);
    read_bits(9, part);
    check("partial9", part, 16'h01FF);
    check("sdo_before_rst", SDO, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_sdo", SDO, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_overrun", overrun, 1'b0);
    CNV = 1'b1;
    mode = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (busy || overrun) busy_seen++;
    end
    check("cnv_high_thru_rst", busy_seen, 0);
    CNV = 1'b0;
    repeat (5) @(negedge clk);
    run_conv("post_rst", 0, 0, 0, 28, 0);
    read_word("post_rst", 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
